// File: rtl/sram_ctrl.sv
// sram_ctrl: splits each 32-bit MEM-stage load/store into two half-word
// cycles on a 16-bit asynchronous SRAM, followed by a programmable settle
// wait. While an access is in flight, ready is held low to freeze the pipeline.
module sram_ctrl #(
    parameter int WAIT_CYCLES = 2,    // idle cycles after the two half-words, 0..15
    parameter int BASE_ADDR   = 1024  // byte address of SRAM word 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [2:0] {IDLE, LO, HI, WAIT, DONE} state_t;

    // Last value of the wait counter before leaving WAIT.
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state, state_nxt;
    logic        is_wr;
    logic [16:0] word;
    logic [31:0] wdata;
    logic [3:0]  cnt;
    logic        req;
    logic [16:0] word_in;

    assign req     = rd_en | wr_en;
    // Addresses below BASE_ADDR wrap; byte-offset bits [1:0] drop out.
    assign word_in = 17'((address - 32'(BASE_ADDR)) >> 2);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Latch the access when it leaves IDLE; later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_wr <= 1'b0;
            word  <= '0;
            wdata <= '0;
        end else if (state == IDLE && req) begin
            is_wr <= wr_en;
            word  <= word_in;
            wdata <= write_data;
        end
    end

    // Settle counter: runs only in WAIT, cleared otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                cnt <= '0;
        else if (state == WAIT) cnt <= cnt + 4'd1;
        else                    cnt <= '0;
    end

    // Assemble load data; held through writes and idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data <= '0;
        end else if (!is_wr) begin
            if (state == LO) read_data[15:0]  <= sram_dq_in;
            if (state == HI) read_data[31:16] <= sram_dq_in;
        end
    end

    // Next state and SRAM strobes/bus decoded from the current state.
    always_comb begin
        state_nxt   = state;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_ce_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_we_n   = 1'b1;
        sram_ub_n   = 1'b1;
        sram_lb_n   = 1'b1;
        case (state)
            IDLE: begin
                ready = ~req;
                if (req) state_nxt = LO;
            end
            LO, HI: begin
                sram_addr   = {word, (state == HI)};
                sram_dq_out = (state == HI) ? wdata[31:16] : wdata[15:0];
                sram_dq_oe  = is_wr;
                sram_ce_n   = 1'b0;
                sram_ub_n   = 1'b0;
                sram_lb_n   = 1'b0;
                sram_oe_n   = is_wr;
                sram_we_n   = ~is_wr;
                if (state == LO)          state_nxt = HI;
                else if (WAIT_CYCLES > 0) state_nxt = WAIT;
                else                      state_nxt = DONE;
            end
            WAIT: begin
                if (cnt == WAIT_LAST) state_nxt = DONE;
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: two controllers (WAIT_CYCLES 2 and 0), each on its own
// combinational SRAM model. Stimulus pushes expected completions into a
// per-controller queue; a negedge monitor pops them when ready rises.
module tb_sram_ctrl;

    typedef struct {
        logic [31:0] rd;
        int          frz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en[2], wr_en[2], ready[2];
    logic [31:0] address[2], write_data[2], read_data[2];
    logic [17:0] sram_addr[2];
    logic [15:0] dq_out[2], dq_in[2];
    logic        dq_oe[2], ce_n[2], oe_n[2], we_n[2], ub_n[2], lb_n[2];

    logic [15:0] mem0 [0:262143];
    logic [15:0] mem1 [0:262143];

    exp_t q0[$], q1[$];
    int   busy[2];
    int   we_cnt[2];
    logic cur_wr[2];
    int   tests = 0, fails = 0;

    always #5 clk = ~clk;

    sram_ctrl #(.WAIT_CYCLES(2), .BASE_ADDR(1024)) dut0 (
        .clk(clk), .rst(rst), .rd_en(rd_en[0]), .wr_en(wr_en[0]),
        .address(address[0]), .write_data(write_data[0]), .read_data(read_data[0]),
        .ready(ready[0]), .sram_addr(sram_addr[0]), .sram_dq_out(dq_out[0]),
        .sram_dq_in(dq_in[0]), .sram_dq_oe(dq_oe[0]), .sram_ce_n(ce_n[0]),
        .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]), .sram_ub_n(ub_n[0]), .sram_lb_n(lb_n[0]));

    sram_ctrl #(.WAIT_CYCLES(0), .BASE_ADDR(1024)) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd_en[1]), .wr_en(wr_en[1]),
        .address(address[1]), .write_data(write_data[1]), .read_data(read_data[1]),
        .ready(ready[1]), .sram_addr(sram_addr[1]), .sram_dq_out(dq_out[1]),
        .sram_dq_in(dq_in[1]), .sram_dq_oe(dq_oe[1]), .sram_ce_n(ce_n[1]),
        .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]), .sram_ub_n(ub_n[1]), .sram_lb_n(lb_n[1]));

    // SRAM models: combinational read, write on the clock edge while we_n is low.
    assign dq_in[0] = mem0[sram_addr[0]];
    assign dq_in[1] = mem1[sram_addr[1]];
    always @(posedge clk) if (!ce_n[0] && !we_n[0]) mem0[sram_addr[0]] <= dq_out[0];
    always @(posedge clk) if (!ce_n[1] && !we_n[1]) mem1[sram_addr[1]] <= dq_out[1];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: strobe sanity every cycle, scoreboard pop on each completion.
    task automatic mon(input int d);
        exp_t        e;
        logic [4:0]  exp_s;
        if (rst) begin
            busy[d] = 0;
            return;
        end
        if (!we_n[d]) we_cnt[d]++;
        if (ce_n[d])        exp_s = 5'b11110;
        else if (cur_wr[d]) exp_s = 5'b10001;
        else                exp_s = 5'b01000;
        chk($sformatf("strobes dut%0d", d),
            {27'd0, oe_n[d], we_n[d], ub_n[d], lb_n[d], dq_oe[d]}, {27'd0, exp_s});
        if (!ready[d]) begin
            busy[d]++;
        end else if (busy[d] > 0) begin
            if (d == 0 && q0.size() > 0) e = q0.pop_front();
            else if (d == 1 && q1.size() > 0) e = q1.pop_front();
            else begin
                e.rd = 32'hx; e.frz = -1;
            end
            chk($sformatf("read_data dut%0d", d), read_data[d], e.rd);
            chk($sformatf("freeze dut%0d", d), busy[d], e.frz);
            busy[d] = 0;
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon(d);
    end

    // One access; pulse drops the request after the first edge and scrambles inputs.
    task automatic access(input int d, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input int frz,
                          input bit pulse);
        exp_t e;
        int   n;
        e.rd = exp_rd; e.frz = frz;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        cur_wr[d] = wr;
        rd_en[d] = rd; wr_en[d] = wr; address[d] = a; write_data[d] = wd;
        if (pulse) begin
            @(posedge clk); #1;
            rd_en[d] = 1'b0; wr_en[d] = 1'b0; address[d] = 32'hFFFF_FFFF; write_data[d] = '0;
        end
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!ready[d] && n < 50);
        if (!ready[d]) begin
            fails++;
            $display("FAIL timeout dut%0d: ready still %b after %0d cycles", d, ready[d], n);
        end
        @(posedge clk); #1;
        rd_en[d] = 1'b0; wr_en[d] = 1'b0; address[d] = '0; write_data[d] = '0;
    endtask

    initial begin
        int w0;
        for (int d = 0; d < 2; d++) begin
            rd_en[d] = 1'b0; wr_en[d] = 1'b0; address[d] = '0; write_data[d] = '0;
            busy[d] = 0; we_cnt[d] = 0; cur_wr[d] = 1'b0;
        end
        // Reset with a request pending.
        rd_en[0] = 1'b1; address[0] = 32'd1024;
        @(posedge clk); #1;
        chk("rst ready with req", {31'd0, ready[0]}, 32'd0);
        chk("rst strobes", {26'd0, ce_n[0], oe_n[0], we_n[0], ub_n[0], lb_n[0], dq_oe[0]}, 32'h3E);
        chk("rst read_data", read_data[0], 32'd0);
        chk("rst sram_addr", {14'd0, sram_addr[0]}, 32'd0);
        rd_en[0] = 1'b0;
        #1;
        chk("rst ready no req", {31'd0, ready[0]}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset during LO abandons the access at once.
        rd_en[0] = 1'b1; address[0] = 32'd1024; cur_wr[0] = 1'b0;
        @(posedge clk); #1;
        chk("LO ce_n", {31'd0, ce_n[0]}, 32'd0);
        rd_en[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("abort ce_n", {31'd0, ce_n[0]}, 32'd1);
        chk("abort ready", {31'd0, ready[0]}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // WAIT_CYCLES=2 controller.
        access(0, 0, 1, 32'd1024, 32'hDEADBEEF, 32'h0, 5, 0);
        chk("mem0[0]", {16'd0, mem0[0]}, 32'hBEEF);
        chk("mem0[1]", {16'd0, mem0[1]}, 32'hDEAD);
        access(0, 1, 0, 32'd1024, 32'h0, 32'hDEADBEEF, 5, 0);
        access(0, 0, 1, 32'd1036, 32'h12345678, 32'hDEADBEEF, 5, 0);
        chk("mem0[6]", {16'd0, mem0[6]}, 32'h5678);
        chk("mem0[7]", {16'd0, mem0[7]}, 32'h1234);
        access(0, 1, 0, 32'd1037, 32'h0, 32'h12345678, 5, 0);
        access(0, 1, 0, 32'd1024, 32'h0, 32'hDEADBEEF, 5, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("post-drop ready", {31'd0, ready[0]}, 32'd1);
        chk("post-drop ce_n", {31'd0, ce_n[0]}, 32'd1);
        w0 = we_cnt[0];
        access(0, 1, 1, 32'd1028, 32'hA5A50F0F, 32'hDEADBEEF, 5, 0);
        chk("both we cycles", we_cnt[0] - w0, 32'd2);
        chk("mem0[2]", {16'd0, mem0[2]}, 32'h0F0F);
        chk("mem0[3]", {16'd0, mem0[3]}, 32'hA5A5);
        access(0, 0, 1, 32'd1020, 32'hCAFEF00D, 32'hDEADBEEF, 5, 0);
        chk("wrap lo", {16'd0, mem0[18'h3FFFE]}, 32'hF00D);
        chk("wrap hi", {16'd0, mem0[18'h3FFFF]}, 32'hCAFE);
        access(0, 1, 0, 32'd1028, 32'h0, 32'hA5A50F0F, 5, 0);

        // WAIT_CYCLES=0 controller, back-to-back.
        access(1, 0, 1, 32'd1024, 32'h22221111, 32'h0, 3, 0);
        access(1, 0, 1, 32'd1028, 32'h44443333, 32'h0, 3, 0);
        access(1, 1, 0, 32'd1024, 32'h0, 32'h22221111, 3, 0);
        access(1, 1, 0, 32'd1028, 32'h0, 32'h44443333, 3, 0);
        chk("mem1[3]", {16'd0, mem1[3]}, 32'h4444);

        repeat (3) @(posedge clk);
        #1;
        chk("q0 drained", q0.size(), 32'd0);
        chk("q1 drained", q1.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
